// File: rtl/frame_histogram.sv
// frame_histogram
//
// Per-frame pixel intensity histogram. Valid pixels (fv_i && lv_i) are binned
// into an on-chip RAM of NBINS counters. When the frame ends, the histogram is
// streamed out over a valid/ready interface in ascending bin order. Each bin is
// zeroed as its beat is accepted, so the next frame starts from an empty table.
//
// Ports
//   clk_i         pixel clock, all logic on the rising edge
//   reset_i       synchronous active-high reset, re-enters CLEAR
//   pd_i          pixel data
//   fv_i, lv_i    frame valid / line valid
//   hist_valid_o  histogram beat valid
//   hist_ready_i  downstream accepts the beat when high together with valid
//   hist_data_o   bin count of the current beat
//   hist_bin_o    bin index of the current beat
//   hist_last_o   high on the beat for bin NBINS-1
//   busy_o        high in CLEAR, DRAIN and READOUT
//   frame_cnt_o   histograms fully read out (wraps)
//   drop_cnt_o    frames dropped because the block was busy (saturates)
module frame_histogram #(
    parameter int PIXEL_W  = 10,
    parameter int BIN_BITS = 10,
    parameter int CNT_W    = 24
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [PIXEL_W-1:0]  pd_i,
    input  logic                fv_i,
    input  logic                lv_i,
    output logic                hist_valid_o,
    input  logic                hist_ready_i,
    output logic [CNT_W-1:0]    hist_data_o,
    output logic [BIN_BITS-1:0] hist_bin_o,
    output logic                hist_last_o,
    output logic                busy_o,
    output logic [15:0]         frame_cnt_o,
    output logic [7:0]          drop_cnt_o
);

    localparam int NBINS = 1 << BIN_BITS;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        ACCUM,
        DRAIN,
        READOUT
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]    mem [NBINS];
    logic [CNT_W-1:0]    ram_q;
    logic [BIN_BITS-1:0] rd_addr;
    logic [BIN_BITS-1:0] wr_addr;
    logic [CNT_W-1:0]    wr_data;
    logic                wr_en;

    logic                fv_q;
    logic                fv_rise;
    logic                pix_ok;
    logic                accept;
    logic                drop;
    logic                drain_cnt;
    logic [BIN_BITS-1:0] idx;
    logic                idx_at_last;
    logic [BIN_BITS-1:0] pix_bin;

    logic                s1_valid;
    logic [BIN_BITS-1:0] s1_bin;
    logic                s2_valid;
    logic [BIN_BITS-1:0] s2_bin;
    logic [CNT_W-1:0]    s2_val;
    logic [CNT_W-1:0]    base;
    logic [CNT_W-1:0]    inc_val;

    logic [15:0]         frame_cnt;
    logic [7:0]          drop_cnt;

    assign pix_bin     = pd_i[PIXEL_W-1 -: BIN_BITS];
    assign fv_rise     = fv_i && !fv_q;
    assign idx_at_last = (idx == {BIN_BITS{1'b1}});

    // The RAM is read-first, so a bin written on the same edge it is read
    // returns the stale count. Only the immediately preceding pixel can be in
    // flight, so a single forward from the S2 register covers every case.
    assign base    = (s2_valid && (s2_bin == s1_bin)) ? s2_val : ram_q;
    assign inc_val = (base == {CNT_W{1'b1}}) ? base : base + CNT_W'(1);

    // fv_q tracks fv_i through reset so a frame already in progress when the
    // block wakes up is never mistaken for a fresh rising edge.
    always_ff @(posedge clk_i) begin
        fv_q <= fv_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pix_ok     = 1'b0;
        accept     = 1'b0;
        drop       = 1'b0;
        rd_addr    = '0;
        case (state)
            CLEAR: begin
                drop = fv_rise;
                if (idx_at_last) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                rd_addr = pix_bin;
                if (fv_rise) begin
                    next_state = ACCUM;
                    pix_ok     = lv_i;
                end
            end
            ACCUM: begin
                rd_addr = pix_bin;
                if (!fv_i) begin
                    next_state = DRAIN;
                end else begin
                    pix_ok = lv_i;
                end
            end
            DRAIN: begin
                // rd_addr stays at bin 0 so its count is ready on READOUT entry
                drop = fv_rise;
                if (drain_cnt) begin
                    next_state = READOUT;
                end
            end
            READOUT: begin
                drop    = fv_rise;
                accept  = hist_ready_i;
                // Prefetch the next bin only when the current one is taken,
                // which keeps hist_data_o stable under backpressure.
                rd_addr = accept ? idx + BIN_BITS'(1) : idx;
                if (accept && idx_at_last) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = CLEAR;
            end
        endcase
    end

    // Single write port: pipelined increments, then bin clears.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = s1_bin;
        wr_data = inc_val;
        if (reset_i) begin
            wr_en = 1'b0;
        end else if (s1_valid) begin
            wr_en = 1'b1;
        end else if (state == CLEAR || accept) begin
            wr_en   = 1'b1;
            wr_addr = idx;
            wr_data = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        ram_q <= mem[rd_addr];
    end

    // idx is shared by CLEAR and READOUT; both end by wrapping it to 0.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx       <= '0;
            drain_cnt <= 1'b0;
            s1_valid  <= 1'b0;
            s1_bin    <= '0;
            s2_valid  <= 1'b0;
            s2_bin    <= '0;
            s2_val    <= '0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            s1_valid  <= pix_ok;
            s1_bin    <= pix_bin;
            s2_valid  <= s1_valid;
            s2_bin    <= s1_bin;
            s2_val    <= inc_val;
            drain_cnt <= (state == DRAIN) ? !drain_cnt : 1'b0;
            if (state == CLEAR || accept) begin
                idx <= idx + BIN_BITS'(1);
            end
            if (accept && idx_at_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign hist_valid_o = (state == READOUT) && !reset_i;
    assign hist_data_o  = hist_valid_o ? ram_q : '0;
    assign hist_bin_o   = hist_valid_o ? idx : '0;
    assign hist_last_o  = hist_valid_o && idx_at_last;
    assign busy_o       = !reset_i &&
                          (state == CLEAR || state == DRAIN || state == READOUT);
    assign frame_cnt_o  = reset_i ? '0 : frame_cnt;
    assign drop_cnt_o   = reset_i ? '0 : drop_cnt;

endmodule

// File: tb/tb_frame_histogram.sv
// tb_frame_histogram
//
// Directed bench for frame_histogram. Two instances share every input: the
// default 24-bit counter build and a 4-bit counter build used to observe
// saturation. Inputs are driven and outputs sampled on the falling edge.
module tb_frame_histogram;

    localparam int PIXEL_W  = 10;
    localparam int BIN_BITS = 10;
    localparam int CNT_W    = 24;
    localparam int SAT_W    = 4;
    localparam int NBINS    = 1 << BIN_BITS;

    logic                clk = 1'b0;
    logic                reset;
    logic                fv;
    logic                lv;
    logic                ready;
    logic [PIXEL_W-1:0]  pd;

    logic                hv, hl, busy;
    logic [CNT_W-1:0]    hd;
    logic [BIN_BITS-1:0] hb;
    logic [15:0]         fcnt;
    logic [7:0]          dcnt;

    logic                shv, shl, sbusy;
    logic [SAT_W-1:0]    shd;
    logic [BIN_BITS-1:0] shb;
    logic [15:0]         sfcnt;
    logic [7:0]          sdcnt;

    int compared   = 0;
    int mismatched = 0;
    int expHist[NBINS];
    int gotHist[NBINS];
    int gotSat[NBINS];
    int pixQ[$];

    int seqFwd[7] = '{5, 5, 5, 6, 5, 6, 6};
    int seqBp[8]  = '{0, 1, 2, 1023, 512, 512, 3, 0};

    always #5 clk = ~clk;

    frame_histogram #(
        .PIXEL_W (PIXEL_W),
        .BIN_BITS(BIN_BITS),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .pd_i        (pd),
        .fv_i        (fv),
        .lv_i        (lv),
        .hist_valid_o(hv),
        .hist_ready_i(ready),
        .hist_data_o (hd),
        .hist_bin_o  (hb),
        .hist_last_o (hl),
        .busy_o      (busy),
        .frame_cnt_o (fcnt),
        .drop_cnt_o  (dcnt)
    );

    frame_histogram #(
        .PIXEL_W (PIXEL_W),
        .BIN_BITS(BIN_BITS),
        .CNT_W   (SAT_W)
    ) dutSat (
        .clk_i       (clk),
        .reset_i     (reset),
        .pd_i        (pd),
        .fv_i        (fv),
        .lv_i        (lv),
        .hist_valid_o(shv),
        .hist_ready_i(ready),
        .hist_data_o (shd),
        .hist_bin_o  (shb),
        .hist_last_o (shl),
        .busy_o      (sbusy),
        .frame_cnt_o (sfcnt),
        .drop_cnt_o  (sdcnt)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic releaseReset();
        int busyCycles = 0;
        int satBusy    = 0;
        int validSeen  = 0;
        reset = 1'b0;
        #1;
        while (busy && busyCycles < 4 * NBINS) begin
            busyCycles++;
            if (sbusy) satBusy++;
            if (hv) validSeen++;
            @(negedge clk);
        end
        checkOutput("clear_busy_cycles", busyCycles, NBINS);
        checkOutput("sat_clear_busy_cycles", satBusy, NBINS);
        checkOutput("clear_no_valid", validSeen, 0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        fv    = 1'b0;
        lv    = 1'b0;
        ready = 1'b0;
        pd    = '0;
        #1;
        checkOutput("reset_valid", int'(hv), 0);
        checkOutput("reset_data", int'(hd), 0);
        checkOutput("reset_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        checkOutput("reset_bin", int'(hb), 0);
        checkOutput("reset_last", int'(hl), 0);
        checkOutput("reset_frame_cnt", int'(fcnt), 0);
        checkOutput("reset_drop_cnt", int'(dcnt), 0);
        releaseReset();
    endtask

    // Sends one frame of nLines lines, each line being the pixels in pixQ,
    // and records the expected bin counts.
    task automatic applyStimulus(input int nLines, input bit lvWithFv);
        int n = 0;
        fv = 1'b1;
        if (!lvWithFv) begin
            lv = 1'b0;
            @(negedge clk);
        end
        for (int l = 0; l < nLines; l++) begin
            foreach (pixQ[p]) begin
                lv = 1'b1;
                pd = PIXEL_W'(pixQ[p]);
                expHist[pixQ[p] >> (PIXEL_W - BIN_BITS)]++;
                @(negedge clk);
            end
            lv = 1'b0;
            @(negedge clk);
        end
        fv = 1'b0;
        while (!hv && n < 4) begin
            @(negedge clk);
            n++;
        end
        checkOutput("valid_within_4_cycles", int'(hv), 1);
    endtask

    // Accepts up to maxBeats beats with the given ready probability. When
    // dropStart >= 0 a frame of bin-7 pixels is driven during the readout.
    task automatic collectReadout(input int readyPct, input int maxBeats, input int dropStart,
                                  output int beats, output int cycles);
        int               badOrder  = 0;
        int               badLast   = 0;
        int               badSat    = 0;
        int               unstable  = 0;
        logic             prevValid = 1'b0;
        logic             prevReady = 1'b0;
        logic [CNT_W-1:0] prevData  = '0;
        logic [BIN_BITS-1:0] prevBin = '0;
        logic             prevLast  = 1'b0;
        beats  = 0;
        cycles = 0;
        foreach (gotHist[b]) begin
            gotHist[b] = -1;
            gotSat[b]  = -1;
        end
        while (beats < maxBeats && cycles < 20000) begin
            if (prevValid && !prevReady &&
                (!hv || hd != prevData || hb != prevBin || hl != prevLast)) begin
                unstable++;
            end
            ready = (int'($urandom_range(99)) < readyPct);
            if (dropStart >= 0 && beats >= dropStart && beats < dropStart + 20) begin
                fv = 1'b1;
                lv = 1'b1;
                pd = PIXEL_W'(7);
            end else begin
                fv = 1'b0;
                lv = 1'b0;
            end
            if (shv && ready) begin
                gotSat[shb] = int'(shd);
                if (shl != (shb == {BIN_BITS{1'b1}})) badSat++;
            end
            if (hv && ready) begin
                gotHist[hb] = int'(hd);
                if (int'(hb) != beats) badOrder++;
                if (hl != (hb == {BIN_BITS{1'b1}})) badLast++;
                beats++;
            end
            prevValid = hv;
            prevReady = ready;
            prevData  = hd;
            prevBin   = hb;
            prevLast  = hl;
            cycles++;
            @(negedge clk);
        end
        ready = 1'b0;
        fv    = 1'b0;
        lv    = 1'b0;
        checkOutput("beat_count", beats, maxBeats);
        checkOutput("bin_order", badOrder, 0);
        checkOutput("last_flag", badLast, 0);
        checkOutput("sat_last_flag", badSat, 0);
        checkOutput("hold_under_backpressure", unstable, 0);
        if (maxBeats == NBINS) begin
            checkOutput("valid_low_after_last", int'(hv), 0);
        end
    endtask

    task automatic compareHist(input string tag);
        int wrong = 0;
        foreach (expHist[b]) begin
            if (gotHist[b] != expHist[b]) wrong++;
            expHist[b] = 0;
        end
        checkOutput(tag, wrong, 0);
    endtask

    initial begin
        int beats;
        int cycles;
        int idleValid;
        int idleBusy;
        int satOther;
        reset = 1'b1;
        fv    = 1'b0;
        lv    = 1'b0;
        ready = 1'b0;
        pd    = '0;
        foreach (expHist[b]) expHist[b] = 0;
        @(negedge clk);

        $display("[TB] reset and clear");
        doReset();
        idleValid = 0;
        idleBusy  = 0;
        repeat (20) begin
            lv = 1'b1;
            pd = PIXEL_W'(3);
            if (hv) idleValid++;
            if (busy) idleBusy++;
            @(negedge clk);
        end
        lv = 1'b0;
        checkOutput("idle_no_valid", idleValid, 0);
        checkOutput("idle_not_busy", idleBusy, 0);

        $display("[TB] 4x8 frame of 0x155");
        pixQ.delete();
        repeat (8) pixQ.push_back('h155);
        applyStimulus(4, 1'b0);
        collectReadout(100, NBINS, -1, beats, cycles);
        checkOutput("one_beat_per_cycle", cycles, NBINS);
        checkOutput("bin155_count", gotHist['h155], 32);
        compareHist("frame_0x155_hist");
        checkOutput("frame_cnt_1", int'(fcnt), 1);

        $display("[TB] back-to-back forwarding");
        fv = 1'b0;
        lv = 1'b1;
        pd = PIXEL_W'(9);
        repeat (2) @(negedge clk);
        pixQ.delete();
        foreach (seqFwd[i]) pixQ.push_back(seqFwd[i]);
        applyStimulus(1, 1'b1);
        collectReadout(100, NBINS, -1, beats, cycles);
        checkOutput("bin5_count", gotHist[5], 4);
        checkOutput("bin6_count", gotHist[6], 3);
        compareHist("forward_hist");
        checkOutput("frame_cnt_2", int'(fcnt), 2);

        $display("[TB] random backpressure, then clear-on-read");
        pixQ.delete();
        foreach (seqBp[i]) pixQ.push_back(seqBp[i]);
        applyStimulus(3, 1'b0);
        collectReadout(50, NBINS, -1, beats, cycles);
        checkOutput("bp_bin0_count", gotHist[0], 6);
        checkOutput("bp_bin512_count", gotHist[512], 6);
        compareHist("backpressure_hist");
        checkOutput("frame_cnt_3", int'(fcnt), 3);
        pixQ.delete();
        repeat (10) pixQ.push_back('h3FF);
        applyStimulus(1, 1'b0);
        collectReadout(100, NBINS, -1, beats, cycles);
        checkOutput("bin1023_count", gotHist[1023], 10);
        compareHist("clear_on_read_hist");
        checkOutput("frame_cnt_4", int'(fcnt), 4);

        $display("[TB] frame dropped during readout");
        pixQ.delete();
        repeat (16) pixQ.push_back('h040);
        applyStimulus(1, 1'b0);
        collectReadout(100, NBINS, 200, beats, cycles);
        checkOutput("drop_bin64_count", gotHist['h040], 16);
        compareHist("drop_readout_hist");
        checkOutput("drop_cnt_1", int'(dcnt), 1);
        checkOutput("sat_drop_cnt_1", int'(sdcnt), 1);
        checkOutput("frame_cnt_5", int'(fcnt), 5);
        pixQ.delete();
        repeat (4) pixQ.push_back('h100);
        applyStimulus(1, 1'b0);
        collectReadout(100, NBINS, -1, beats, cycles);
        checkOutput("after_drop_bin256", gotHist['h100], 4);
        checkOutput("after_drop_bin7", gotHist[7], 0);
        compareHist("after_drop_hist");
        checkOutput("frame_cnt_6", int'(fcnt), 6);

        $display("[TB] counter saturation");
        pixQ.delete();
        repeat (20) pixQ.push_back('h0AA);
        applyStimulus(1, 1'b0);
        collectReadout(100, NBINS, -1, beats, cycles);
        checkOutput("wide_bin_count", gotHist['h0AA], 20);
        checkOutput("narrow_bin_saturated", gotSat['h0AA], 15);
        satOther = 0;
        foreach (gotSat[b]) begin
            if (b != 'h0AA && gotSat[b] != 0) satOther++;
        end
        checkOutput("narrow_other_bins", satOther, 0);
        compareHist("saturation_hist");
        checkOutput("sat_frame_cnt_7", int'(sfcnt), 7);

        $display("[TB] reset in the middle of a readout");
        pixQ.delete();
        repeat (8) pixQ.push_back('h300);
        applyStimulus(1, 1'b0);
        collectReadout(100, 100, -1, beats, cycles);
        foreach (expHist[b]) expHist[b] = 0;
        doReset();
        pixQ.delete();
        repeat (5) pixQ.push_back('h2AA);
        applyStimulus(1, 1'b0);
        collectReadout(100, NBINS, -1, beats, cycles);
        checkOutput("post_reset_bin682", gotHist['h2AA], 5);
        checkOutput("post_reset_bin768", gotHist['h300], 0);
        compareHist("post_reset_hist");
        checkOutput("post_reset_frame_cnt", int'(fcnt), 1);
        checkOutput("post_reset_drop_cnt", int'(dcnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
